// File: rtl/double_trouble_pkg.sv
// Shared constants and types for the "at least two of four" threshold detector.
`timescale 1ns/1ps

package double_trouble_pkg;

  // Fixed shape of the detector: four single-bit inputs, fire on two or more.
  localparam int DT_NUM_INPUTS = 4;
  localparam int DT_COUNT_W    = 3;

  // 3 bits so that the all-ones case (4) is representable.
  typedef logic [DT_COUNT_W-1:0]    dt_count_t;
  typedef logic [DT_NUM_INPUTS-1:0] dt_bits_t;

  // Typed so comparisons against a count stay width-matched.
  localparam dt_count_t DT_THRESHOLD = 3'd2;

endpackage : double_trouble_pkg

// File: rtl/double_trouble_popcount4.sv
// Combinational 4-bit to 3-bit population counter.
`timescale 1ns/1ps

module popcount4
  import double_trouble_pkg::*;
(
  input  logic [DT_NUM_INPUTS-1:0] bits,
  output logic [DT_COUNT_W-1:0]    count
);

  // Sum the zero-extended input bits.
  always_comb begin
    // NOTE: blocking assignments in always_comb, with a default first so the
    // accumulator never holds a value from a previous evaluation (no latch).
    count = '0;
    for (int i = 0; i < DT_NUM_INPUTS; i++) begin
      count = count + dt_count_t'(bits[i]);
    end
  end

endmodule : popcount4

// File: rtl/double_trouble.sv
// "At least two of four" detector: combinational decision and population
// count, plus a registered copy of the decision for clocked consumers.
`timescale 1ns/1ps

module double_trouble
  import double_trouble_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0,
  input  logic                  in1,
  input  logic                  in2,
  input  logic                  in3,
  output logic                  out,
  output logic [DT_COUNT_W-1:0] count,
  output logic                  out_q
);

  dt_bits_t bits;

  assign bits = {in3, in2, in1, in0};

  popcount4 u_popcount4 (
    .bits  (bits),
    .count (count)
  );

  // Decision is independent of clk and rst; it always follows the inputs.
  assign out = (count >= DT_THRESHOLD);

  // Register the decision; reset clears it immediately, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
      out_q <= out;
    end
  end

endmodule : double_trouble

// File: tb/tb_double_trouble.sv
// Directed bench for double_trouble: exhaustive combinational sweep, boundary
// patterns, the registered path and asynchronous reset behaviour.
`timescale 1ns/1ps

module tb_double_trouble;

  logic       clk;
  logic       rst;
  logic       in0;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       out;
  logic [2:0] count;
  logic       out_q;

  int n_vec;
  int n_err;

  // Hand-computed reference tables indexed by {in3,in2,in1,in0}.
  // out is 0 only for patterns 0, 1, 2, 4, 8.
  logic [15:0] out_tbl;
  int          cnt_tbl [16];

  double_trouble dut (
    .clk   (clk),
    .rst   (rst),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .out   (out),
    .count (count),
    .out_q (out_q)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic [3:0] p);
    {in3, in2, in1, in0} = p;
  endtask

  // One full clock pulse; outputs are sampled afterwards, well clear of the rising edge.
  task automatic tick();
    #2 clk = 1'b1;
    #2 clk = 1'b0;
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    out_tbl = 16'hFEE8;
    cnt_tbl = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};
    clk     = 1'b0;
    rst     = 1'b1;
    apply(4'b0000);

    // Reset state.
    #1;
    check("reset_out_q", {7'd0, out_q}, 8'd0);
    rst = 1'b0;
    #1;

    // Exhaustive sweep with the clock idle, 2 time units per pattern.
    for (int p = 0; p < 16; p++) begin
      apply(p[3:0]);
      #1;
      check($sformatf("sweep_out_%0d", p), {7'd0, out}, {7'd0, out_tbl[p]});
      check($sformatf("sweep_count_%0d", p), {5'd0, count}, 8'(cnt_tbl[p]));
      #1;
    end

    // Boundary patterns.
    apply(4'b0000); #1;
    check("bnd_0000_count", {5'd0, count}, 8'd0);
    check("bnd_0000_out", {7'd0, out}, 8'd0);
    apply(4'b1111); #1;
    check("bnd_1111_count", {5'd0, count}, 8'd4);
    check("bnd_1111_out", {7'd0, out}, 8'd1);
    apply(4'b0011); #1;
    check("bnd_0011_out", {7'd0, out}, 8'd1);
    apply(4'b1000); #1;
    check("bnd_1000_out", {7'd0, out}, 8'd0);

    // Registered path.
    apply(4'b0101); #1;
    tick();
    check("reg_0101_out_q", {7'd0, out_q}, 8'd1);
    apply(4'b0100); #1;
    check("reg_0100_hold_out_q", {7'd0, out_q}, 8'd1);
    tick();
    check("reg_0100_out_q", {7'd0, out_q}, 8'd0);

    // Asynchronous reset while out_q is high.
    apply(4'b1111); #1;
    tick();
    check("pre_rst_out_q", {7'd0, out_q}, 8'd1);
    rst = 1'b1; #1;
    check("async_rst_out_q", {7'd0, out_q}, 8'd0);
    check("async_rst_out", {7'd0, out}, 8'd1);
    rst = 1'b0; #1;
    check("post_rst_no_edge_out_q", {7'd0, out_q}, 8'd0);
    tick();
    check("post_rst_edge_out_q", {7'd0, out_q}, 8'd1);

    // Reset held across several edges.
    apply(4'b0110);
    rst = 1'b1; #1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("rst_hold_out_q_%0d", e), {7'd0, out_q}, 8'd0);
      check($sformatf("rst_hold_out_%0d", e), {7'd0, out}, 8'd1);
      check($sformatf("rst_hold_count_%0d", e), {5'd0, count}, 8'd2);
    end
    rst = 1'b0; #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_double_trouble
